seq_add16_ctrl: RTL
===================

SEQ_ADD16_CTRL -- requirements
Module: seq_add16_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, setting the number of 4-bit nibbles per operand (operand width W = 4*NIBBLES, legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, marking the operand set as valid.
REQ-005 The block SHALL have port in_ready, output, 1, high when the block can accept operands.
REQ-006 The block SHALL have ports a and b, input, W each, the addend operands.
REQ-007 The block SHALL have port cin, input, 1, the carry-in for the least significant nibble.
REQ-008 The block SHALL have port out_valid, output, 1, high when the result is presented.
REQ-009 The block SHALL have port out_ready, input, 1, consumer acceptance of the result.
REQ-010 The block SHALL have port sum, output, W, the registered result.
REQ-011 The block SHALL have port cout, output, 1, the registered final carry-out.
REQ-012 The block SHALL have port busy, output, 1, high in RUN or DONE.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; a transfer occurs when in_valid && in_ready at a clock edge.
REQ-015 On transfer, the block SHALL latch a and b into operand shift registers, load the carry register with cin, clear the nibble counter, and enter RUN.
REQ-016 Each RUN cycle SHALL add the current low nibbles of the operand registers plus the carry register through one 4-bit adder slice.
REQ-017 Each RUN cycle SHALL write the 4-bit result into sum bits [4k+3:4k] for counter value k, update the carry register with the slice carry-out, and shift the operands right by 4.
REQ-018 RUN SHALL last exactly NIBBLES cycles, with the counter going 0..NIBBLES-1.
REQ-019 On the edge that processes nibble NIBBLES-1, the FSM SHALL enter DONE and cout SHALL take the final carry.
REQ-020 out_valid SHALL go high exactly NIBBLES cycles after the transfer edge.
REQ-021 In DONE, out_valid SHALL be 1, and sum and cout SHALL stay stable until out_valid && out_ready.
REQ-022 On out_valid && out_ready, the FSM SHALL return to IDLE.
REQ-023 sum and cout SHALL keep their values in IDLE until the next transfer.
REQ-024 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored there, and a, b and cin changes have no effect.
REQ-025 If out_ready is already high when DONE is entered, the return to IDLE SHALL happen on the next edge (out_valid high for one cycle).
REQ-026 Arithmetic SHALL be modulo 2^W; overflow is reported only through cout, and the carry SHALL propagate across every nibble boundary, including a full-length ripple from 0xF...F + 1.
REQ-027 The nibble counter SHALL be wide enough for NIBBLES-1 and SHALL never wrap inside RUN.
REQ-028 out_valid SHALL be a registered output with no combinational path from in_valid or out_ready.

Reset
REQ-029 When rst=1 at a clock edge, the state SHALL become IDLE; out_valid, busy, cout, sum, the counter, the carry register and the operand registers SHALL be 0, and in_ready SHALL be 1 from the next cycle.
REQ-030 Reset SHALL take priority over every transfer and handshake, including an assertion mid-RUN or in DONE; the partial result is discarded and no out_valid is produced for it.

Structure
REQ-031 Package seq_add_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the constant NIBBLE_W = 4.
REQ-032 One sub-module nibble_add4 SHALL be instantiated exactly once: a combinational 4-bit ripple adder with ports a[3:0], b[3:0], cin, sum[3:0] and cout, built from full-adder cells.
REQ-033 The block SHALL contain only the FSM, the counter, the shift registers and the carry register; there SHALL be no W-wide combinational adder.

Verification
REQ-034 The bench SHALL cover: a=0x1234, b=0x4321, cin=0 -> out_valid exactly 4 cycles after transfer, sum=0x5555, cout=0.
REQ-035 The bench SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
REQ-036 The bench SHALL cover: out_ready held low for 3 cycles in DONE -> sum, cout and out_valid stable, in_ready=0; the in_valid pulses applied meanwhile are not accepted, and the result is released on the first out_ready=1.
REQ-037 The bench SHALL cover: rst asserted on the 2nd RUN cycle of 0x00FF+0x0001 -> next cycle IDLE, in_ready=1, out_valid=0, sum=0; then 0x0F0F+0x0101 -> sum=0x1010, cout=0.
REQ-038 The bench SHALL cover back-to-back operations with out_ready tied to 1 and in_valid held high -> one accepted operation per NIBBLES+2 cycles, each result correct against a reference model over 200 random operands.
REQ-039 The bench SHALL cover the NIBBLES=2 parameter override: 0xFF+0x01 -> out_valid 2 cycles after transfer, sum=0x00, cout=1.

Source files
------------

// File: rtl/seq_add_pkg.sv
// rtl/seq_add_pkg.sv - shared types and constants for the nibble-serial adder
package seq_add_pkg;

  // Width of one adder slice; operands are processed this many bits per cycle.
  localparam int NIBBLE_W = 4;

  // Controller states: waiting for operands, stepping nibbles, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add4.sv
// rtl/nibble_add4.sv - combinational 4-bit ripple adder built from full-adder cells
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Carry chain: c[0] is the slice carry-in, c[4] the slice carry-out.
  logic [4:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit, rippling the carry upward.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign sum[i]   = p ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (p & c[i]);
  end

  assign cout = c[4];

endmodule

// File: rtl/seq_add16_ctrl.sv
// rtl/seq_add16_ctrl.sv - nibble-serial adder with valid/ready operand and result handshakes
module seq_add16_ctrl
  import seq_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          cout,
  output logic                          busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_t           state;
  state_t           state_nxt;

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     sum_q;
  logic             cout_q;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  logic accept;
  logic last_nibble;

  // The only adder in the block: it always sees the low nibble of each operand.
  nibble_add4 u_slice (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign in_ready    = (state == IDLE);
  assign accept      = in_valid && in_ready;
  assign last_nibble = (cnt_q == LAST_CNT);

  // Outputs are decoded from registered state only, so nothing on the
  // input side can reach out_valid combinationally.
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  // State register; reset wins over any handshake in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: accept, step through every nibble, hold until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_nibble) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, per-nibble shift/accumulate and final carry capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          carry_q <= slice_cout;
          for (int k = 0; k < NIBBLES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              sum_q[k*NIBBLE_W +: NIBBLE_W] <= slice_sum;
            end
          end
          // The counter parks on the last index rather than wrapping.
          if (last_nibble) begin
            cout_q <= slice_cout;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          // DONE: result registers hold until the consumer takes them.
        end
      endcase
    end
  end

endmodule
